// File: rtl/fcs_pkg.sv
// Shared constants for the FCS generator/checker pair: CRC polynomials, seeds,
// good-frame residues, the host register map and the checker FSM encoding.
package fcs_pkg;

  localparam logic [31:0] POLY16 = 32'h0000_8408;
  localparam logic [31:0] POLY32 = 32'hEDB8_8320;
  localparam logic [31:0] INIT16 = 32'h0000_FFFF;
  localparam logic [31:0] INIT32 = 32'hFFFF_FFFF;
  localparam logic [15:0] RES16  = 16'hF0B8;
  localparam logic [31:0] RES32  = 32'hDEBB_20E3;

  localparam logic [2:0] A_STAT = 3'd0;
  localparam logic [2:0] A_BCNT = 3'd1;
  localparam logic [2:0] A_CRCL = 3'd2;
  localparam logic [2:0] A_CRCH = 3'd3;
  localparam logic [2:0] A_CTL  = 3'd3;
  localparam logic [2:0] A_GOOD = 3'd4;
  localparam logic [2:0] A_BAD  = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One-byte reflected CRC update, CRC-16 CCITT (low half only) or CRC-32.
// Shared between the TX FCS generator and the RX checker.
module crc_byte_step
  import fcs_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  d,
  input  logic        mode,
  output logic [31:0] nxt
);

  always_comb begin
    logic [31:0] c;
    logic [31:0] poly;
    // In CRC-16 mode the upper half is forced to zero and stays zero.
    c    = mode ? crc : {16'h0000, crc[15:0]};
    poly = mode ? POLY32 : POLY16;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ poly;
      else             c = c >> 1;
    end
    nxt = c;
  end

endmodule

// File: rtl/fcs_check8.sv
// Receive-side FCS checker: per-byte CRC over the deframed stream, residue
// verdict per frame, sticky status and good/bad/byte counters on the I/O bus.
module fcs_check8
  import fcs_pkg::*;
#(
  parameter int MINLEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iocs,
  input  logic [2:0]  ioaddr,
  input  logic [15:0] din,
  input  logic        iowr,
  input  logic        iord,
  output logic [15:0] dout,
  input  logic [7:0]  rxd,
  input  logic        rxstb,
  input  logic        rxsof,
  input  logic        rxeof,
  input  logic        rxabort,
  output logic        fcsdone,
  output logic        fcsok,
  output logic        irq
);

  localparam logic [15:0] MINLEN16 = 16'(MINLEN);

  logic [1:0]  state;
  logic [31:0] crc;
  logic [15:0] bytecnt, goodcnt, badcnt;
  logic        fmode, mode, irqen;
  logic        done, abort, runt;
  logic        fcsdone_p1, fcsok_p1;

  logic        in_run, byte_v, start, cont, abort_v, restart;
  logic        end_ok, verdict, match, good, is_runt;
  logic        new_mode, stat_rd, ctl_wr, cnt_clr;
  logic [31:0] crc_in, crc_nx;
  logic [15:0] bytecnt_nx;
  logic        unused_din;

  assign unused_din = ^din[15:3];

  assign in_run  = (state == S_RUN);
  // A deframer abort always drops the byte presented in the same cycle.
  assign byte_v  = rxstb & ~rxabort;
  assign start   = byte_v & rxsof;
  assign cont    = in_run & byte_v & ~rxsof;
  assign abort_v = in_run & rxabort;
  assign restart = in_run & start;

  assign new_mode   = start ? mode : fmode;
  assign crc_in     = start ? (mode ? INIT32 : INIT16) : crc;
  assign bytecnt_nx = start ? 16'd1 : sat_inc16(bytecnt);

  crc_byte_step u_step (
    .crc  (crc_in),
    .d    (rxd),
    .mode (new_mode),
    .nxt  (crc_nx)
  );

  assign end_ok  = (start | cont) & rxeof;
  assign verdict = end_ok | restart | abort_v;
  assign match   = new_mode ? (crc_nx == RES32) : (crc_nx[15:0] == RES16);
  assign good    = end_ok & ~restart & match & (bytecnt_nx >= MINLEN16);
  assign is_runt = end_ok & (bytecnt_nx < MINLEN16);

  assign stat_rd = iocs & iord & (ioaddr == A_STAT);
  assign ctl_wr  = iocs & iowr & (ioaddr == A_CTL);
  assign cnt_clr = ctl_wr & din[1];

  // Frame FSM, CRC and byte counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      crc     <= INIT32;
      bytecnt <= '0;
      fmode   <= 1'b0;
    end else if (abort_v) begin
      state <= S_IDLE;
    end else if (start | cont) begin
      crc     <= crc_nx;
      bytecnt <= bytecnt_nx;
      state   <= rxeof ? S_DONE : S_RUN;
      if (start) fmode <= mode;
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end

  // Verdict stage: registered one cycle after the closing strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      fcsdone_p1 <= 1'b0;
      fcsok_p1   <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
      runt       <= 1'b0;
    end else begin
      fcsdone_p1 <= verdict;
      if (verdict) fcsok_p1 <= good;
      done  <= (done  & ~stat_rd) | verdict;
      abort <= (abort & ~stat_rd) | abort_v | restart;
      runt  <= (runt  & ~stat_rd) | is_runt;
    end
  end

  // Control register and frame counters; clear beats a coincident increment
  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= 1'b0;
      irqen   <= 1'b0;
      goodcnt <= '0;
      badcnt  <= '0;
    end else begin
      if (ctl_wr) begin
        mode  <= din[0];
        irqen <= din[2];
      end
      if (cnt_clr) begin
        goodcnt <= '0;
        badcnt  <= '0;
      end else if (verdict) begin
        if (good) goodcnt <= sat_inc16(goodcnt);
        else      badcnt  <= sat_inc16(badcnt);
      end
    end
  end

  assign fcsdone = fcsdone_p1;
  assign fcsok   = fcsok_p1;
  assign irq     = done & irqen;

  always_comb begin
    dout = '0;
    if (iocs & iord) begin
      case (ioaddr)
        A_STAT:  dout = {11'b0, runt, abort, mode, fcsok_p1, done};
        A_BCNT:  dout = bytecnt;
        A_CRCL:  dout = crc[15:0];
        A_CRCH:  dout = fmode ? crc[31:16] : 16'h0000;
        A_GOOD:  dout = goodcnt;
        A_BAD:   dout = badcnt;
        default: dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fcs_check8.sv
// Directed bench for fcs_check8: known-good CRC-16/CRC-32 frames, corrupted,
// runt, aborted, restarted and reset-interrupted frames, verdicts via a queue.
module tb_fcs_check8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iocs = 1'b0, iowr = 1'b0, iord = 1'b0;
  logic [2:0]  ioaddr = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic [7:0]  rxd = '0;
  logic        rxstb = 1'b0, rxsof = 1'b0, rxeof = 1'b0, rxabort = 1'b0;
  logic        fcsdone, fcsok, irq;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic        exp_q[$];
  logic [7:0]  frm[$];
  logic [15:0] rv;

  fcs_check8 #(.MINLEN(4)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .ioaddr(ioaddr), .din(din),
    .iowr(iowr), .iord(iord), .dout(dout), .rxd(rxd), .rxstb(rxstb),
    .rxsof(rxsof), .rxeof(rxeof), .rxabort(rxabort), .fcsdone(fcsdone),
    .fcsok(fcsok), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sof, input logic eof);
    rxd = b; rxstb = 1'b1; rxsof = sof; rxeof = eof;
    tick();
    rxstb = 1'b0; rxsof = 1'b0; rxeof = 1'b0;
  endtask

  task automatic send_frm(input logic do_sof, input logic do_eof);
    for (int i = 0; i < frm.size(); i++)
      send_byte(frm[i], do_sof && (i == 0), do_eof && (i == frm.size() - 1));
  endtask

  task automatic take_verdict(input string tag);
    logic e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
    chk({tag, "_done"}, {31'b0, fcsdone}, 32'd1);
    chk({tag, "_ok"}, {31'b0, fcsok}, {31'b0, e});
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    iocs = 1'b1; iord = 1'b1; ioaddr = a;
    #1 v = dout;
    tick();
    iocs = 1'b0; iord = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] v);
    iocs = 1'b1; iowr = 1'b1; ioaddr = a; din = v;
    tick();
    iocs = 1'b0; iowr = 1'b0; din = '0;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] v;
    rd(a, v);
    chk(tag, {16'b0, v}, {16'b0, exp});
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_fcsdone", {31'b0, fcsdone}, 0);
    chk("rst_fcsok", {31'b0, fcsok}, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_dout_idle", {16'b0, dout}, 0);
    chk_reg("rst_stat", 3'd0, 16'h0000);
    chk_reg("rst_crcl", 3'd2, 16'hFFFF);
    chk_reg("rst_good", 3'd4, 16'h0000);

    // good CRC-16 frame
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    exp_q.push_back(1'b1);
    send_frm(1'b1, 1'b1);
    take_verdict("c16");
    tick();
    chk("c16_pulse", {31'b0, fcsdone}, 0);
    chk_reg("c16_stat", 3'd0, 16'h0003);
    chk_reg("c16_bcnt", 3'd1, 16'd11);
    chk_reg("c16_crcl", 3'd2, 16'hF0B8);
    chk_reg("c16_crch", 3'd3, 16'h0000);
    chk_reg("c16_good", 3'd4, 16'd1);

    // good CRC-32 frame
    wr(3'd3, 16'h0001);
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    exp_q.push_back(1'b1);
    send_frm(1'b1, 1'b1);
    take_verdict("c32");
    chk_reg("c32_stat", 3'd0, 16'h0007);
    chk_reg("c32_crcl", 3'd2, 16'h20E3);
    chk_reg("c32_crch", 3'd3, 16'hDEBB);
    chk_reg("c32_bcnt", 3'd1, 16'd13);
    chk_reg("c32_good", 3'd4, 16'd2);

    // corrupted CRC-16 frame with interrupt enabled
    wr(3'd3, 16'h0004);
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6F, 8'h90};
    exp_q.push_back(1'b0);
    send_frm(1'b1, 1'b1);
    take_verdict("bad");
    chk("bad_irq", {31'b0, irq}, 1);
    chk_reg("bad_badcnt", 3'd5, 16'd1);
    chk_reg("bad_good", 3'd4, 16'd2);
    chk_reg("bad_stat", 3'd0, 16'h0001);
    chk("bad_irq_clr", {31'b0, irq}, 0);

    // runt
    frm = '{8'h00, 8'h00};
    exp_q.push_back(1'b0);
    send_frm(1'b1, 1'b1);
    take_verdict("runt");
    chk_reg("runt_stat", 3'd0, 16'h0011);
    chk_reg("runt_bcnt", 3'd1, 16'd2);
    chk_reg("runt_bad", 3'd5, 16'd2);

    // deframer abort after 5 bytes
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    send_frm(1'b1, 1'b0);
    chk("abt_nodone", {31'b0, fcsdone}, 0);
    exp_q.push_back(1'b0);
    rxabort = 1'b1;
    tick();
    rxabort = 1'b0;
    take_verdict("abt");
    chk_reg("abt_stat", 3'd0, 16'h0009);
    chk_reg("abt_bad", 3'd5, 16'd3);

    // sof mid-frame kills the old frame, new frame is good
    frm = '{8'h31, 8'h32, 8'h33};
    send_frm(1'b1, 1'b0);
    exp_q.push_back(1'b0);
    send_byte(8'h31, 1'b1, 1'b0);
    take_verdict("rs_old");
    frm = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    exp_q.push_back(1'b1);
    send_frm(1'b0, 1'b1);
    take_verdict("rs_new");
    chk_reg("rs_bad", 3'd5, 16'd4);
    chk_reg("rs_good", 3'd4, 16'd3);
    chk_reg("rs_stat", 3'd0, 16'h000B);
    chk_reg("rs_stat_clr", 3'd0, 16'h0002);

    // counter clear
    wr(3'd3, 16'h0002);
    chk_reg("clr_good", 3'd4, 16'd0);
    chk_reg("clr_bad", 3'd5, 16'd0);

    // reset mid-frame, then a good frame
    frm = '{8'h31, 8'h32, 8'h33};
    send_frm(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_fcsdone", {31'b0, fcsdone}, 0);
    chk_reg("mrst_bcnt", 3'd1, 16'd0);
    chk_reg("mrst_bad", 3'd5, 16'd0);
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    exp_q.push_back(1'b1);
    send_frm(1'b1, 1'b1);
    take_verdict("mrst");
    chk_reg("mrst_good", 3'd4, 16'd1);
    chk_reg("mrst_bad2", 3'd5, 16'd0);
    chk("q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
